// File: rtl/trace_pkg.sv
// Shared types for the commit trace buffer: FSM states,
// record flag positions and the record width derivation.
package trace_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_HALTED  = 2'd2,
    S_TIMEOUT = 2'd3
  } state_e;

  localparam int FLAG_REG   = 0;
  localparam int FLAG_LOAD  = 1;
  localparam int FLAG_STORE = 2;
  localparam int FLAG_HLT   = 3;

  function automatic int rec_w(input int dw, input int aw);
    return 4 * dw + aw + 4;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Record FIFO with an occupancy counter and a selectable
// full policy: drop the newest push or evict the oldest entry.
module trace_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter bit OVERWRITE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop_req,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             pop;
  logic             wr_en;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);
  assign pop   = pop_req & ~empty;
  assign dout  = empty ? '0 : mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    drop   = 1'b0;
    if (push && full && !pop) begin
      drop = 1'b1;
      // Full and not popping: the write slot aliases the head.
      if (OVERWRITE) begin
        wr_en  = 1'b1;
        wptr_d = wptr_q + 1'b1;
        rptr_d = rptr_q + 1'b1;
      end
    end else begin
      if (push) begin
        wr_en  = 1'b1;
        wptr_d = wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_d = rptr_q + 1'b1;
      end
      cnt_d = cnt_q + {{AW{1'b0}}, push}
                    - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q] <= din;
    end
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace capture: run/halt/timeout FSM, saturating
// event counters and a FIFO of per-instruction records.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_AW     = 4,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 100000,
  parameter bit OVERWRITE  = 1'b0,
  localparam int REC_W     = rec_w(DATA_W, REG_AW)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] pc,
  input  logic              reg_we,
  input  logic [REG_AW-1:0] reg_wa,
  input  logic [DATA_W-1:0] reg_wd,
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              hlt,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [REC_W-1:0]  rec_data,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  inst_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic [1:0]        state,
  output logic              done
);

  localparam logic [CNT_W-1:0] LIMIT =
    CNT_W'(MAX_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] inst_q, inst_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic              run;
  logic              push;
  logic              store;
  logic              load;
  logic [3:0]        flags;
  logic [DATA_W-1:0] mem_data;
  logic [REC_W-1:0]  rec_in;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_drop;
  logic              lost;

  assign run   = (state_q == S_RUN);
  assign store = mem_we;
  assign load  = mem_re & ~mem_we;
  assign push  = run & (reg_we | mem_re | mem_we | hlt);
  assign lost  = fifo_drop & fifo_full;

  always_comb begin
    flags = '0;
    flags[FLAG_HLT]   = hlt;
    flags[FLAG_STORE] = store;
    flags[FLAG_LOAD]  = load;
    flags[FLAG_REG]   = reg_we;
  end

  always_comb begin
    mem_data = '0;
    if (store) begin
      mem_data = mem_wdata;
    end else if (load) begin
      mem_data = mem_rdata;
    end
  end

  assign rec_in = {flags, pc,
                   reg_we ? reg_wa : '0,
                   reg_we ? reg_wd : '0,
                   mem_addr, mem_data};

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    inst_d  = inst_q;
    drop_d  = drop_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        // A halt on the last allowed cycle beats the watchdog.
        if (hlt) begin
          state_d = S_HALTED;
        end else if (cyc_q == LIMIT) begin
          state_d = S_TIMEOUT;
        end
      end
      S_HALTED, S_TIMEOUT: begin
      end
    endcase
    if (run && cyc_q != '1) begin
      cyc_d = cyc_q + 1'b1;
    end
    if (run && (hlt | reg_we | mem_we) && inst_q != '1) begin
      inst_d = inst_q + 1'b1;
    end
    if (lost && drop_q != '1) begin
      drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      inst_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      inst_q  <= inst_d;
      drop_q  <= drop_d;
    end
  end

  trace_fifo #(
    .WIDTH     (REC_W),
    .DEPTH     (DEPTH),
    .OVERWRITE (OVERWRITE)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .din     (rec_in),
    .pop_req (rec_ready),
    .dout    (rec_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .drop    (fifo_drop)
  );

  assign rec_valid   = ~fifo_empty;
  assign cycle_count = cyc_q;
  assign inst_count  = inst_q;
  assign drop_count  = drop_q;
  assign state       = state_q;
  assign done        = (state_q == S_HALTED) |
                       (state_q == S_TIMEOUT);

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench: two DEPTH=4 instances (drop / evict policy)
// share stimulus; a negedge monitor pops expected records.
module tb_commit_trace_buffer;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int RW = 4 * DW + AW + 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] pc = '0;
  logic          reg_we = 1'b0;
  logic [AW-1:0] reg_wa = '0;
  logic [DW-1:0] reg_wd = '0;
  logic          mem_re = 1'b0;
  logic          mem_we = 1'b0;
  logic [DW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic          hlt = 1'b0;
  logic          rdy0 = 1'b0;
  logic          rdy1 = 1'b0;

  logic          v0, v1, done0, done1;
  logic [RW-1:0] d0, d1;
  logic [CW-1:0] cyc0, inst0, drop0;
  logic [CW-1:0] cyc1, inst1, drop1;
  logic [1:0]    st0, st1;

  int total = 0;
  int bad = 0;
  logic [RW-1:0] q0 [$];
  logic [RW-1:0] q1 [$];
  logic [RW-1:0] r;
  logic [RW-1:0] keep [6];

  always #5 clk = ~clk;

  commit_trace_buffer #(
    .DATA_W(DW), .REG_AW(AW), .DEPTH(4), .CNT_W(CW),
    .MAX_CYCLES(8), .OVERWRITE(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst), .start(start), .pc(pc),
    .reg_we(reg_we), .reg_wa(reg_wa), .reg_wd(reg_wd),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .hlt(hlt),
    .rec_valid(v0), .rec_ready(rdy0), .rec_data(d0),
    .cycle_count(cyc0), .inst_count(inst0),
    .drop_count(drop0), .state(st0), .done(done0)
  );

  commit_trace_buffer #(
    .DATA_W(DW), .REG_AW(AW), .DEPTH(4), .CNT_W(CW),
    .MAX_CYCLES(8), .OVERWRITE(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start), .pc(pc),
    .reg_we(reg_we), .reg_wa(reg_wa), .reg_wd(reg_wd),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .hlt(hlt),
    .rec_valid(v1), .rec_ready(rdy1), .rec_data(d1),
    .cycle_count(cyc1), .inst_count(inst1),
    .drop_count(drop1), .state(st1), .done(done1)
  );

  task automatic chk(input string n, input logic [79:0] a,
                     input logic [79:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask

  function automatic logic [RW-1:0] rec(
    input logic [3:0] f, input logic [15:0] p,
    input logic [3:0] wa, input logic [15:0] wd,
    input logic [15:0] a, input logic [15:0] md);
    return {f, p, wa, wd, a, md};
  endfunction

  always @(negedge clk) begin
    if (!rst && v0 && rdy0) begin
      if (q0.size() == 0) chk("rec0_extra", d0, '0);
      else chk("rec0", d0, q0.pop_front());
    end
    if (!rst && v1 && rdy1) begin
      if (q1.size() == 0) chk("rec1_extra", d1, '0);
      else chk("rec1", d1, q1.pop_front());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    start = 0; pc = '0; reg_we = 0; reg_wa = '0;
    reg_wd = '0; mem_re = 0; mem_we = 0; mem_addr = '0;
    mem_wdata = '0; mem_rdata = '0; hlt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr();
    q0.delete();
    q1.delete();
    cyc();
    rst = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic commit(
    input logic [15:0] p, input logic we,
    input logic [3:0] wa, input logic [15:0] wd,
    input logic re, input logic mw, input logic [15:0] a,
    input logic [15:0] wdat, input logic [15:0] rdat,
    input logic h);
    pc = p; reg_we = we; reg_wa = wa; reg_wd = wd;
    mem_re = re; mem_we = mw; mem_addr = a;
    mem_wdata = wdat; mem_rdata = rdat; hlt = h;
    cyc();
    clr();
  endtask

  task automatic both(input string n, input logic [79:0] a0,
                      input logic [79:0] a1,
                      input logic [79:0] e);
    chk({n, "_0"}, a0, e);
    chk({n, "_1"}, a1, e);
  endtask

  task automatic push_both(input logic [RW-1:0] x);
    q0.push_back(x);
    q1.push_back(x);
  endtask

  initial begin
    repeat (2) cyc();
    both("rst_state", st0, st1, 0);
    both("rst_valid", v0, v1, 0);
    both("rst_done", done0, done1, 0);
    both("rst_data", d0, d1, 0);
    both("rst_cyc", cyc0, cyc1, 0);
    rst = 1'b0;
    cyc();

    // register write, store with mem_re, load, halt
    rdy0 = 1; rdy1 = 1;
    go();
    both("run", st0, st1, 1);
    push_both(rec(4'b0001, 16'h0010, 4'd3, 16'h1234, 0, 0));
    commit(16'h0010, 1, 3, 16'h1234, 0, 0, 0, 0, 0, 0);
    both("t1_valid", v0, v1, 1);
    both("t1_inst", inst0, inst1, 1);
    push_both(rec(4'b0100, 16'h0014, 0, 0,
                  16'h0040, 16'hBEEF));
    commit(16'h0014, 0, 5, 16'hAAAA, 1, 1, 16'h0040,
           16'hBEEF, 16'h1111, 0);
    both("t2_inst", inst0, inst1, 2);
    push_both(rec(4'b0010, 16'h0018, 0, 0,
                  16'h0044, 16'h5555));
    commit(16'h0018, 0, 0, 0, 1, 0, 16'h0044,
           16'h9999, 16'h5555, 0);
    both("load_inst", inst0, inst1, 2);
    push_both(rec(4'b1000, 16'h001C, 0, 0, 0, 0));
    commit(16'h001C, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    both("hlt_state", st0, st1, 2);
    both("hlt_done", done0, done1, 1);
    both("hlt_inst", inst0, inst1, 3);
    both("hlt_cyc", cyc0, cyc1, 4);
    go();
    commit(16'h0020, 1, 1, 16'h7777, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc();
    both("term_state", st0, st1, 2);
    both("term_inst", inst0, inst1, 3);
    both("term_cyc", cyc0, cyc1, 4);
    both("drain1", q0.size(), q1.size(), 0);

    // six pushes into a stalled four-deep FIFO
    do_reset();
    rdy0 = 0; rdy1 = 0;
    go();
    for (int i = 0; i < 6; i++) begin
      r = rec(4'b0001, 16'(i * 4), 4'(i),
              16'(16'h0100 + i), 0, 0);
      keep[i] = r;
      if (i < 4) q0.push_back(r);
      if (i >= 2) q1.push_back(r);
      commit(16'(i * 4), 1, 4'(i), 16'(16'h0100 + i),
             0, 0, 0, 0, 0, 0);
    end
    both("ovf_drop", drop0, drop1, 2);
    chk("hold_0", d0, keep[0]);
    chk("head_1", d1, keep[2]);
    rdy0 = 1; rdy1 = 1;
    repeat (6) cyc();
    both("drain2", q0.size(), q1.size(), 0);
    both("empty2", v0, v1, 0);

    // full FIFO with simultaneous push and pop
    do_reset();
    rdy0 = 0; rdy1 = 0;
    go();
    for (int i = 0; i < 4; i++) begin
      push_both(rec(4'b0001, 16'(16'h0200 + i), 4'(i),
                    16'(i), 0, 0));
      commit(16'(16'h0200 + i), 1, 4'(i), 16'(i),
             0, 0, 0, 0, 0, 0);
    end
    rdy0 = 1; rdy1 = 1;
    push_both(rec(4'b0001, 16'h0204, 4'd4, 16'd4, 0, 0));
    commit(16'h0204, 1, 4, 4, 0, 0, 0, 0, 0, 0);
    rdy0 = 0; rdy1 = 0;
    both("pp_drop", drop0, drop1, 0);
    r = rec(4'b0001, 16'h0205, 4'd5, 16'd5, 0, 0);
    void'(q1.pop_front());
    q1.push_back(r);
    commit(16'h0205, 1, 5, 5, 0, 0, 0, 0, 0, 0);
    both("pp_full", drop0, drop1, 1);
    rdy0 = 1; rdy1 = 1;
    repeat (6) cyc();
    both("drain3", q0.size(), q1.size(), 0);

    // watchdog, then halt on the last allowed cycle
    do_reset();
    go();
    repeat (7) cyc();
    both("wd7_state", st0, st1, 1);
    both("wd7_cyc", cyc0, cyc1, 7);
    cyc();
    both("wd_state", st0, st1, 3);
    both("wd_cyc", cyc0, cyc1, 8);
    both("wd_done", done0, done1, 1);
    repeat (3) cyc();
    both("wd_hold", cyc0, cyc1, 8);
    do_reset();
    go();
    repeat (7) cyc();
    push_both(rec(4'b1000, 16'h0030, 0, 0, 0, 0));
    commit(16'h0030, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    both("h8_state", st0, st1, 2);
    both("h8_cyc", cyc0, cyc1, 8);
    both("h8_inst", inst0, inst1, 1);
    repeat (2) cyc();
    both("drain4", q0.size(), q1.size(), 0);

    // asynchronous reset with three records queued
    do_reset();
    rdy0 = 0; rdy1 = 0;
    go();
    for (int i = 0; i < 3; i++) begin
      commit(16'(i), 1, 1, 16'(i), 0, 0, 0, 0, 0, 0);
    end
    both("pre_valid", v0, v1, 1);
    #2 rst = 1'b1;
    #1;
    q0.delete();
    q1.delete();
    both("ar_valid", v0, v1, 0);
    both("ar_data", d0, d1, 0);
    both("ar_state", st0, st1, 0);
    both("ar_cyc", cyc0, cyc1, 0);
    both("ar_inst", inst0, inst1, 0);
    both("ar_drop", drop0, drop1, 0);
    both("ar_done", done0, done1, 0);
    cyc();
    rst = 1'b0;
    rdy0 = 1; rdy1 = 1;
    go();
    repeat (2) cyc();
    both("ar_flushed", v0, v1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
